iter_multiplier: RTL and testbench

- Sequential shift-add multiplier directly downstream of the 16x32 register file.
- Consumes the two read ports (read_data1/read_data2) as operands. Produces a 32-bit product, plus destination address and write enable, that drive the register file write port (write_data, write_addr, wr_en).
- Implements MUL (Rd = Rn*Rm, low 32 bits) and MLA (Rd = Rn*Rm + Ra). Multi-cycle with a start/busy/done handshake; the control unit stalls while busy.

---
 rtl/mul_pkg.sv | 17 +
 rtl/iter_multiplier.sv | 134 +++++++++++++
 tb/tb_iter_multiplier.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mul_pkg;

    // Control states: waiting for a request, iterating, presenting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Default operand/result width; also the number of RUN iterations.
    localparam int MUL_WIDTH = 32;

    // Width of the iteration counter for the default width.
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

endpackage

// File: rtl/iter_multiplier.sv
// Iterative unsigned shift-add multiplier (MUL / MLA) feeding the register
// file write port. Fixed latency: WIDTH RUN cycles followed by one DONE cycle.
module iter_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH  = MUL_WIDTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              accumulate,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [WIDTH-1:0]  acc_in,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  result,
    output logic              flag_n,
    output logic              flag_z
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t       state;
    mul_state_t       state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] product;
    logic [CNT_W-1:0] count;

    logic             last_iter;
    logic [WIDTH-1:0] product_step;

    // The final iteration is the one where the counter sits at WIDTH-1.
    assign last_iter    = (count == CNT_W'(WIDTH - 1));

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set; the carry out of the top bit is discarded.
    assign product_step = mplier[0] ? (product + mcand) : product;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The register file write strobe is exactly the completion pulse.
    assign wr_en = done;

    // Operand capture, shift-add datapath and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
            result  <= '0;
            wr_addr <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Operands are captured only on the accepting edge, so the
                    // read ports are free to change for the rest of the run.
                    if (start) begin
                        mcand   <= op_a;
                        mplier  <= op_b;
                        wr_addr <= dest_addr;
                        product <= accumulate ? acc_in : '0;
                        count   <= '0;
                    end
                end
                RUN: begin
                    product <= product_step;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + CNT_W'(1);
                    // Publish the finished product on the edge entering DONE so
                    // it is already valid while done/wr_en are high.
                    if (last_iter) begin
                        result <= product_step;
                        flag_n <= product_step[WIDTH-1];
                        flag_z <= (product_step == '0);
                    end
                end
                default: begin
                    // DONE: everything holds; control returns to IDLE.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier: a cycle-level transaction model
// checked every cycle, plus directed operations with hand-computed results.
module tb_iter_multiplier;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int LATENCY = W + 1;   // start edge to DONE cycle, in cycles

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          accumulate;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  acc_in;
    logic [AW-1:0] dest_addr;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  result;
    logic          flag_n;
    logic          flag_z;

    iter_multiplier #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .op_a       (op_a),
        .op_b       (op_b),
        .acc_in     (acc_in),
        .dest_addr  (dest_addr),
        .busy       (busy),
        .done       (done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .result     (result),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Transaction model: an accepted request keeps the unit busy for
    // LATENCY cycles; the last of them is the completion cycle, in which the
    // full-width product (mod 2^W) becomes the visible result.
    // ---------------------------------------------------------------------
    int           m_left = 0;     // busy cycles remaining, including current
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_res  = '0;
    logic [AW-1:0] m_addr = '0;
    logic         m_n    = 1'b0;
    logic         m_z    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_res  = '0;
            m_addr = '0;
            m_n    = 1'b0;
            m_z    = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_res = m_pend;
                m_n   = m_pend[W-1];
                m_z   = (m_pend == '0);
            end
        end else if (start) begin
            m_left = LATENCY;
            m_addr = dest_addr;
            m_pend = op_a * op_b + (accumulate ? acc_in : '0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic cmp_en = 1'b0;
    int   n_done = 0;

    always @(negedge clk) begin
        if (done) n_done++;
        if (cmp_en) begin
            check("busy",    W'(busy),    W'(m_left > 0));
            check("done",    W'(done),    W'(m_left == 1));
            check("wr_en",   W'(wr_en),   W'(m_left == 1));
            check("result",  result,      m_res);
            check("wr_addr", W'(wr_addr), W'(m_addr));
            check("flag_n",  W'(flag_n),  W'(m_n));
            check("flag_z",  W'(flag_z),  W'(m_z));
        end
    end

    // Issue one request on the next edge, zero the operand inputs right after
    // the start edge, and wait (bounded) for completion.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic acc,
                          input logic [AW-1:0] addr,
                          output int lat, output logic [W-1:0] res);
        @(negedge clk);
        op_a = a; op_b = b; acc_in = c; accumulate = acc; dest_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a = '0; op_b = '0; acc_in = '0; accumulate = 1'b0; dest_addr = '0;
        lat = 1;
        while (!done && lat < LATENCY + 8) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
        end
        res = result;
    endtask

    int           lat;
    logic [W-1:0] res;
    int           done_snap;

    initial begin
        reset = 1'b1; start = 1'b0; accumulate = 1'b0;
        op_a = '0; op_b = '0; acc_in = '0; dest_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        check("rst_result", result, 32'd0);
        check("rst_busy",   W'(busy), 32'd0);
        check("rst_flag_z", W'(flag_z), 32'd0);

        // Basic MUL.
        run_op(32'd3, 32'd5, 32'd0, 1'b0, 4'h2, lat, res);
        check("mul_latency", lat, LATENCY);
        check("mul_result",  res, 32'd15);
        check("mul_wr_addr", W'(wr_addr), 32'd2);
        check("mul_flags",   {30'd0, flag_n, flag_z}, 32'd0);

        // MLA with inputs cleared after the start edge.
        run_op(32'd7, 32'd6, 32'd100, 1'b1, 4'h5, lat, res);
        check("mla_result", res, 32'd142);
        check("mla_latency", lat, LATENCY);

        // Wrap and flag cases.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'h1, lat, res);
        check("wrap_result", res, 32'h0000_0001);
        check("wrap_flag_n", W'(flag_n), 32'd0);
        run_op(32'h8000_0000, 32'd2, 32'd0, 1'b0, 4'h3, lat, res);
        check("zero_result", res, 32'd0);
        check("zero_flag_z", W'(flag_z), 32'd1);
        run_op(32'h4000_0000, 32'd2, 32'd0, 1'b0, 4'hF, lat, res);
        check("neg_result", res, 32'h8000_0000);
        check("neg_flag_n", W'(flag_n), 32'd1);
        check("neg_wr_addr", W'(wr_addr), 32'hF);

        // Start while busy is ignored: 2*3 with a 9*9 request mid-run.
        @(negedge clk);
        done_snap = n_done;
        op_a = 32'd2; op_b = 32'd3; dest_addr = 4'h7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        op_a = 32'd9; op_b = 32'd9; dest_addr = 4'h9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = '0; op_b = '0; dest_addr = '0;
        repeat (LATENCY + 10) @(negedge clk);
        check("busy_start_ndone", n_done - done_snap, 32'd1);
        check("busy_start_result", result, 32'd6);
        check("busy_start_addr", W'(wr_addr), 32'd7);

        // Back-to-back: second request in the first IDLE cycle after DONE.
        run_op(32'd5, 32'd5, 32'd0, 1'b0, 4'h4, lat, res);
        check("b2b_first", res, 32'd25);
        run_op(32'd4, 32'd4, 32'd0, 1'b0, 4'h6, lat, res);
        check("b2b_result", res, 32'd16);
        check("b2b_latency", lat, LATENCY);

        // Reset mid-operation aborts without a write.
        @(negedge clk);
        op_a = 32'd10; op_b = 32'd10; dest_addr = 4'hA; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = '0; op_b = '0; dest_addr = '0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", result, 32'd0);
        check("abort_busy",   W'(busy), 32'd0);
        check("abort_addr",   W'(wr_addr), 32'd0);
        done_snap = n_done;
        repeat (40) @(negedge clk);
        check("abort_no_wr", n_done - done_snap, 32'd0);
        run_op(32'd2, 32'd2, 32'd0, 1'b0, 4'h8, lat, res);
        check("after_abort_result", res, 32'd4);
        check("after_abort_latency", lat, LATENCY);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        @(negedge clk);
        check("rst_start_busy", W'(busy), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
